// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: drives a req/gnt/rvalid memory port with one
// outstanding request and queues returned instructions with their PCs for IF_ID.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ifq_valid,
    output logic [31:0] ifq_ins,
    output logic [31:0] ifq_pc,
    input  logic        ifq_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, req_pc;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   ins_q [DEPTH];
    logic [31:0]   pc_q  [DEPTH];

    logic          accept, push, pop;
    logic [31:0]   push_pc;

    assign mem_req   = (state == S_REQ) && (count < FULL) && !redirect;
    assign mem_addr  = fetch_pc;
    assign accept    = mem_req && mem_gnt;
    assign ifq_valid = (count != '0);
    assign pop       = ifq_valid && ifq_ready && !redirect;
    assign ifq_ins   = ifq_valid ? ins_q[rd_ptr] : 32'h0;
    assign ifq_pc    = ifq_valid ? pc_q[rd_ptr]  : 32'h0;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_pc   = fetch_pc;
        unique case (state)
            S_REQ: begin
                if (accept && mem_rvalid) begin
                    push = 1'b1;
                end else if (accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                push_pc = req_pc;
                if (mem_rvalid) begin
                    push      = !redirect;
                    state_nxt = S_REQ;
                end else if (redirect) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (mem_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            ins_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]  <= push_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: per-cycle vector table plus an
// asynchronous-reset-during-wait sequence.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        ifq_valid;
    logic [31:0] ifq_ins;
    logic [31:0] ifq_pc;
    logic        ifq_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .ifq_valid(ifq_valid),
        .ifq_ins(ifq_ins),
        .ifq_pc(ifq_pc),
        .ifq_ready(ifq_ready)
    );

    typedef struct {
        logic        rst;
        logic        rd;
        logic [31:0] rpc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic r, logic rd, logic [31:0] rpc, logic g, logic rv,
        logic [31:0] d, logic rdy, logic er, logic [31:0] ea,
        logic ev, logic [31:0] ep, logic [31:0] ei);
        vec_t v;
        v.rst = r;    v.rd = rd;    v.rpc = rpc;
        v.gnt = g;    v.rv = rv;    v.rdata = d;
        v.rdy = rdy;  v.e_req = er; v.e_addr = ea;
        v.e_val = ev; v.e_pc = ep;  v.e_ins = ei;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic er, logic [31:0] ea,
                           logic ev, logic [31:0] ep, logic [31:0] ei);
        chk({tag, ".mem_req"},   {31'h0, mem_req},   {31'h0, er});
        chk({tag, ".mem_addr"},  mem_addr,           ea);
        chk({tag, ".ifq_valid"}, {31'h0, ifq_valid}, {31'h0, ev});
        chk({tag, ".ifq_pc"},    ifq_pc,             ep);
        chk({tag, ".ifq_ins"},   ifq_ins,            ei);
    endtask

    initial begin
        // streaming, one instruction per cycle
        vecs.push_back(mk(1,0,0,1,1,32'h0,       1, 1,32'h00, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,1,1,32'h10000000,1, 1,32'h00, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,1,1,32'h10000004,1, 1,32'h04, 1,32'h0, 32'h10000000));
        vecs.push_back(mk(0,0,0,1,1,32'h10000008,1, 1,32'h08, 1,32'h4, 32'h10000004));
        vecs.push_back(mk(0,0,0,1,1,32'h1000000C,1, 1,32'h0C, 1,32'h8, 32'h10000008));
        // fill while stalled, full blocks req, then drain
        vecs.push_back(mk(1,0,0,1,1,32'h0,       0, 1,32'h00, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,1,1,32'h10000000,0, 1,32'h00, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,1,1,32'h10000004,0, 1,32'h04, 1,32'h0, 32'h10000000));
        vecs.push_back(mk(0,0,0,1,1,32'h10000008,0, 1,32'h08, 1,32'h0, 32'h10000000));
        vecs.push_back(mk(0,0,0,1,1,32'h1000000C,0, 1,32'h0C, 1,32'h0, 32'h10000000));
        vecs.push_back(mk(0,0,0,1,1,32'h10000010,0, 0,32'h10, 1,32'h0, 32'h10000000));
        vecs.push_back(mk(0,0,0,1,1,32'h10000010,1, 0,32'h10, 1,32'h0, 32'h10000000));
        vecs.push_back(mk(0,0,0,0,0,32'h0,       1, 1,32'h10, 1,32'h4, 32'h10000004));
        vecs.push_back(mk(0,0,0,0,0,32'h0,       1, 1,32'h10, 1,32'h8, 32'h10000008));
        vecs.push_back(mk(0,0,0,0,0,32'h0,       1, 1,32'h10, 1,32'hC, 32'h1000000C));
        vecs.push_back(mk(0,0,0,1,1,32'h10000010,1, 1,32'h10, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,       1, 1,32'h14, 1,32'h10,32'h10000010));
        // two-cycle memory at 0x40
        vecs.push_back(mk(0,1,32'h40,1,0,32'h0,  1, 0,32'h14, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,1,0,32'h0,       1, 1,32'h40, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,1,1,32'h8C010004,0, 0,32'h44, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,       0, 1,32'h44, 1,32'h40,32'h8C010004));
        vecs.push_back(mk(0,0,0,0,0,32'h0,       1, 1,32'h44, 1,32'h40,32'h8C010004));
        // redirect while waiting, stale response two cycles later
        vecs.push_back(mk(0,0,0,1,0,32'h0,       1, 1,32'h44, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,1,32'h100,0,0,32'h0, 1, 0,32'h48, 0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,       1, 0,32'h100,0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,1,1,32'hDEADBEEF,1, 0,32'h100,0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,1,0,32'h0,       1, 1,32'h100,0,32'h0, 32'h0));
        // redirect coinciding with the response
        vecs.push_back(mk(0,1,32'h200,1,1,32'h11111111,1, 0,32'h104,0,32'h0, 32'h0));
        // stray rvalid without accept is ignored
        vecs.push_back(mk(0,0,0,0,1,32'h22222222,1, 1,32'h200,0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,32'h0,       1, 1,32'h200,0,32'h0, 32'h0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst         = vecs[i].rst;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            mem_gnt     = vecs[i].gnt;
            mem_rvalid  = vecs[i].rv;
            mem_rdata   = vecs[i].rdata;
            ifq_ready   = vecs[i].rdy;
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_val, vecs[i].e_pc, vecs[i].e_ins);
        end

        // async reset while waiting with three entries queued
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; ifq_ready = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1;
            mem_rdata = 32'hA0000000 + 32'(k * 4);
        end
        @(negedge clk);
        mem_gnt = 1'b1; mem_rvalid = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1;
        chk_all("rst_pre", 1'b0, 32'h10, 1'b1, 32'h0, 32'hA0000000);
        #2 rst = 1'b1;
        #1;
        chk_all("rst_async", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        mem_rdata = 32'h00005555;
        #1;
        chk_all("rst_rel", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk_all("rst_refetch", 1'b1, 32'h4, 1'b1, 32'h0, 32'h00005555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
